aes_out_scheduler: RTL

In-order result collector between the parallel AES engines and the AXI stream master output FIFO. A message's blocks are dispatched to engines round-robin starting at a given engine. This block pops results back in the same round-robin order, writes each 128-bit block into the output FIFO write port, and raises `processing_done` once the message's last block is written, so the stream master can assert `tlast`.

---
 rtl/aes_out_scheduler_pkg.sv | 28 ++
 rtl/aes_rr_ptr.sv | 40 ++++
 rtl/aes_out_scheduler.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/aes_out_scheduler_pkg.sv
// ============================================================================
// Module      : aes_out_scheduler_pkg
// Description : Shared block geometry and scheduler state encodings.
//               AES_OUT_SCHED_WATCHDOG_EN adds the ERROR state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_out_scheduler_pkg;

  localparam int Nb          = 4;
  localparam int WORD_S      = 32;
  localparam int c_AES_BLK_W = Nb * WORD_S;

  typedef enum logic [1:0] {
    AES_OUT_SCHED_IDLE     = 2'd0,
    AES_OUT_SCHED_WAIT_ENG = 2'd1,
`ifdef AES_OUT_SCHED_WATCHDOG_EN
    AES_OUT_SCHED_WRITE    = 2'd2,
    AES_OUT_SCHED_ERROR    = 2'd3
`else
    AES_OUT_SCHED_WRITE    = 2'd2
`endif
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/aes_rr_ptr.sv
// ============================================================================
// Module      : aes_rr_ptr
// Description : Modulo-N_ENGINES round-robin pointer with load, advance, wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_rr_ptr #(
  parameter int N_ENGINES        = 4,
  parameter int ENGINE_IDX_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_load,
  input  logic [ENGINE_IDX_WIDTH-1:0] i_load_idx,
  input  logic                        i_advance,
  output logic [ENGINE_IDX_WIDTH-1:0] o_ptr
);

  localparam logic [ENGINE_IDX_WIDTH-1:0] c_LAST = ENGINE_IDX_WIDTH'(N_ENGINES - 1);
  localparam logic [ENGINE_IDX_WIDTH-1:0] c_ONE  = ENGINE_IDX_WIDTH'(1);

  logic [ENGINE_IDX_WIDTH-1:0] r_ptr;

  // Out-of-range load values fall back to engine 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= (i_load_idx > c_LAST) ? '0 : i_load_idx;
    end else if (i_advance) begin
      r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + c_ONE;
    end
  end

  assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/aes_out_scheduler.sv
// ============================================================================
// Module      : aes_out_scheduler
// Description : In-order round-robin collector of AES engine results into the
//               output FIFO. Optional watchdog: AES_OUT_SCHED_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_out_scheduler #(
  parameter int N_ENGINES        = 4,
  parameter int ENGINE_IDX_WIDTH = 2,
  parameter int FIFO_DATA_WIDTH  = 128,
  parameter int BLK_CNT_WIDTH    = 16,
  parameter int WDOG_CYCLES      = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cmd_tvalid,
  output logic                                 cmd_tready,
  input  logic [BLK_CNT_WIDTH-1:0]             cmd_blk_cnt,
  input  logic [ENGINE_IDX_WIDTH-1:0]          cmd_first_engine,
  input  logic [N_ENGINES-1:0]                 eng_tvalid,
  output logic [N_ENGINES-1:0]                 eng_tready,
  input  logic [N_ENGINES*FIFO_DATA_WIDTH-1:0] eng_tdata,
  output logic                                 out_fifo_write_tvalid,
  input  logic                                 out_fifo_write_tready,
  output logic [FIFO_DATA_WIDTH-1:0]           aes_controller_out_fifo_data,
  output logic                                 processing_done,
  output logic                                 busy,
  output logic                                 sched_error
);

  import aes_out_scheduler_pkg::*;

  localparam logic [BLK_CNT_WIDTH-1:0] c_CNT_ONE = BLK_CNT_WIDTH'(1);

  if ((FIFO_DATA_WIDTH != c_AES_BLK_W) || (WDOG_CYCLES < 1)) begin : g_param_check
    $error("aes_out_scheduler: FIFO_DATA_WIDTH must equal Nb*WORD_S and WDOG_CYCLES >= 1");
  end

  sched_state_t                r_state;
  sched_state_t                w_state_nxt;
  logic [BLK_CNT_WIDTH-1:0]    r_remaining;
  logic [FIFO_DATA_WIDTH-1:0]  r_data;
  logic                        r_done;
  logic [ENGINE_IDX_WIDTH-1:0] w_ptr;
  logic                        w_cmd_fire;
  logic                        w_pop;
  logic                        w_wr_fire;
  logic                        w_sel_valid;
  logic [FIFO_DATA_WIDTH-1:0]  w_eng_data [N_ENGINES];

  for (genvar gi = 0; gi < N_ENGINES; gi++) begin : g_eng
    assign w_eng_data[gi] = eng_tdata[gi*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
    assign eng_tready[gi] = w_pop && (w_ptr == ENGINE_IDX_WIDTH'(gi));
  end

  assign w_sel_valid = eng_tvalid[w_ptr];

  aes_rr_ptr #(
    .N_ENGINES        (N_ENGINES),
    .ENGINE_IDX_WIDTH (ENGINE_IDX_WIDTH)
  ) u_rr_ptr (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_cmd_fire),
    .i_load_idx (cmd_first_engine),
    .i_advance  (w_wr_fire),
    .o_ptr      (w_ptr)
  );

`ifdef AES_OUT_SCHED_WATCHDOG_EN
  localparam int c_WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [c_WDOG_W-1:0] r_wdog;
  logic                w_wdog_hit;

  assign w_wdog_hit = (r_wdog == c_WDOG_W'(WDOG_CYCLES - 1));

  // Counts consecutive starved cycles while waiting on the expected engine.
  always_ff @(posedge clk) begin
    if (reset || (r_state != AES_OUT_SCHED_WAIT_ENG) || w_pop) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + c_WDOG_W'(1);
    end
  end

  assign sched_error = (r_state == AES_OUT_SCHED_ERROR);
`else
  assign sched_error = 1'b0;
`endif

  always_comb begin
    w_state_nxt           = r_state;
    w_cmd_fire            = 1'b0;
    w_pop                 = 1'b0;
    w_wr_fire             = 1'b0;
    cmd_tready            = 1'b0;
    busy                  = 1'b1;
    out_fifo_write_tvalid = 1'b0;
    case (r_state)
      AES_OUT_SCHED_IDLE: begin
        cmd_tready = 1'b1;
        busy       = 1'b0;
        w_cmd_fire = cmd_tvalid;
        if (cmd_tvalid && (cmd_blk_cnt != '0)) begin
          w_state_nxt = AES_OUT_SCHED_WAIT_ENG;
        end
      end
      AES_OUT_SCHED_WAIT_ENG: begin
        w_pop = w_sel_valid;
        if (w_sel_valid) begin
          w_state_nxt = AES_OUT_SCHED_WRITE;
`ifdef AES_OUT_SCHED_WATCHDOG_EN
        end else if (w_wdog_hit) begin
          w_state_nxt = AES_OUT_SCHED_ERROR;
`endif
        end
      end
      AES_OUT_SCHED_WRITE: begin
        out_fifo_write_tvalid = 1'b1;
        w_wr_fire             = out_fifo_write_tready;
        if (out_fifo_write_tready) begin
          w_state_nxt = (r_remaining == c_CNT_ONE) ? AES_OUT_SCHED_IDLE
                                                   : AES_OUT_SCHED_WAIT_ENG;
        end
      end
`ifdef AES_OUT_SCHED_WATCHDOG_EN
      AES_OUT_SCHED_ERROR: begin
        w_state_nxt = AES_OUT_SCHED_ERROR;
      end
`endif
      default: begin
        w_state_nxt = AES_OUT_SCHED_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= AES_OUT_SCHED_IDLE;
      r_remaining <= '0;
      r_data      <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_fire) begin
        r_remaining <= cmd_blk_cnt;
        r_done      <= (cmd_blk_cnt == '0);
      end
      if (w_pop) begin
        r_data <= w_eng_data[w_ptr];
      end
      if (w_wr_fire) begin
        r_remaining <= r_remaining - c_CNT_ONE;
        if (r_remaining == c_CNT_ONE) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign aes_controller_out_fifo_data = r_data;
  assign processing_done              = r_done;

endmodule

`default_nettype wire
